writeback: RTL

Final stage of the pipelined Y86-64 core, directly downstream of the memory stage. Captures the memory stage's results into the W pipeline register, commits `valE`/`valM` to a 15-entry register file, and exposes the register file's two decode read ports. Also maintains the architectural status (sticky halt on the first non-AOK status) and a retired-instruction counter.

---
 rtl/writeback.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// Y86-64 write-back stage: W pipeline register, 15-entry register file, sticky halt and retire counter.
// Define WB_BYPASS_EN to forward the W-stage write-back values onto the decode read ports.
module writeback #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             W_stall_i,
    input  logic             W_bubble_i,
    input  logic [2:0]       m_stat_i,
    input  logic [3:0]       M_icode_i,
    input  logic [63:0]      M_valE_i,
    input  logic [63:0]      m_valM_i,
    input  logic [3:0]       M_dstE_i,
    input  logic [3:0]       M_dstM_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    output logic [63:0]      d_rvalA_o,
    output logic [63:0]      d_rvalB_o,
    output logic [2:0]       W_stat_o,
    output logic [3:0]       W_icode_o,
    output logic [63:0]      W_valE_o,
    output logic [63:0]      W_valM_o,
    output logic [3:0]       W_dstE_o,
    output logic [3:0]       W_dstM_o,
    output logic [2:0]       Stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam logic [2:0] SAOK  = 3'd1;
    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] RNONE = 4'hF;

    logic [2:0]       r_stat;
    logic [3:0]       r_icode;
    logic [63:0]      r_valE;
    logic [63:0]      r_valM;
    logic [3:0]       r_dstE;
    logic [3:0]       r_dstM;
    logic             r_valid;
    logic [63:0]      r_rf [15];
    logic             r_halted;
    logic [2:0]       r_stat_arch;
    logic [CNT_W-1:0] r_retired;

    logic             w_we;
    logic             w_retire;
    logic             w_halt;
    logic [63:0]      w_rvalA;
    logic [63:0]      w_rvalB;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stat  <= SAOK;
            r_icode <= INOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_valid <= 1'b0;
        end else if (W_stall_i) begin
            r_stat  <= r_stat;
        end else if (W_bubble_i) begin
            r_stat  <= SAOK;
            r_icode <= INOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_valid <= 1'b0;
        end else begin
            r_stat  <= m_stat_i;
            r_icode <= M_icode_i;
            r_valE  <= M_valE_i;
            r_valM  <= m_valM_i;
            r_dstE  <= M_dstE_i;
            r_dstM  <= M_dstM_i;
            r_valid <= 1'b1;
        end
    end

    assign w_we     = (r_stat == SAOK) && !r_halted;
    assign w_retire = r_valid && (r_stat == SAOK) && !W_stall_i && !r_halted;
    assign w_halt   = r_valid && (r_stat != SAOK) && !r_halted;

    // M port is written after E so popq %rsp leaves the loaded value.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 15; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_we) begin
            if (r_dstE != RNONE) begin
                r_rf[r_dstE] <= r_valE;
            end
            if (r_dstM != RNONE) begin
                r_rf[r_dstM] <= r_valM;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_halted    <= 1'b0;
            r_stat_arch <= SAOK;
            r_retired   <= '0;
        end else begin
            if (w_halt) begin
                r_halted    <= 1'b1;
                r_stat_arch <= r_stat;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_rvalA = '0;
        w_rvalB = '0;
        if (d_srcA_i != RNONE) begin
            w_rvalA = r_rf[d_srcA_i];
        end
        if (d_srcB_i != RNONE) begin
            w_rvalB = r_rf[d_srcB_i];
        end
`ifdef WB_BYPASS_EN
        if (w_we && (d_srcA_i != RNONE)) begin
            if (d_srcA_i == r_dstM) begin
                w_rvalA = r_valM;
            end else if (d_srcA_i == r_dstE) begin
                w_rvalA = r_valE;
            end
        end
        if (w_we && (d_srcB_i != RNONE)) begin
            if (d_srcB_i == r_dstM) begin
                w_rvalB = r_valM;
            end else if (d_srcB_i == r_dstE) begin
                w_rvalB = r_valE;
            end
        end
`endif
    end

    assign d_rvalA_o = w_rvalA;
    assign d_rvalB_o = w_rvalB;
    assign W_stat_o  = r_stat;
    assign W_icode_o = r_icode;
    assign W_valE_o  = r_valE;
    assign W_valM_o  = r_valM;
    assign W_dstE_o  = r_dstE;
    assign W_dstM_o  = r_dstM;
    assign Stat_o    = r_stat_arch;
    assign halted_o  = r_halted;
    assign retired_o = r_retired;

endmodule
